// File: rtl/noc_flit_injector.sv
// noc_flit_injector
// Injection stage in front of a NoC router input port. Flits arrive from a
// local source over valid/ready and wait in a small FIFO. A flit leaves the
// FIFO only while a downstream credit is held. The router returns each freed
// slot as a one-cycle credit pulse. Every output is a register or a decode of
// registered state, so credit_i and push_valid never reach an output
// combinationally.

module noc_flit_injector #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CREDITS    = 4,
  parameter int CNT_W      = $clog2(((FIFO_DEPTH > CREDITS) ? FIFO_DEPTH : CREDITS) + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_valid,
  input  logic [DATA_W-1:0] push_data,
  output logic              push_ready,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              credit_i,
  output logic [CNT_W-1:0]  credit_cnt_o,
  output logic [CNT_W-1:0]  fifo_cnt_o,
  output logic              credit_err_o
);

  localparam int              PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CREDITS_C = CNT_W'(CREDITS);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_C    = {CNT_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE_C = PTR_W'(1);

  // Storage and state
  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  fifo_cnt_r;
  logic [CNT_W-1:0]  credit_cnt_r;
  logic              valid_r;
  logic [DATA_W-1:0] data_r;
  logic              err_r;

  // Next-state decode
  logic              push_ready_s;
  logic              push_fire_s;
  logic              send_s;
  logic [CNT_W-1:0]  fifo_cnt_nxt_s;
  logic [CNT_W-1:0]  credit_cnt_nxt_s;
  logic              err_set_s;

  // Handshake, send decision and counter updates, all from pre-edge registered state
  always_comb begin
    push_ready_s     = 1'b0;
    push_fire_s      = 1'b0;
    send_s           = 1'b0;
    fifo_cnt_nxt_s   = fifo_cnt_r;
    credit_cnt_nxt_s = credit_cnt_r;
    err_set_s        = 1'b0;

    // Registered count only: a pop this cycle frees its slot next cycle
    if (rst) begin
      push_ready_s = 1'b0;
    end else begin
      push_ready_s = (fifo_cnt_r < DEPTH_C);
    end

    push_fire_s = push_valid && push_ready_s;
    send_s      = (fifo_cnt_r != ZERO_C) && (credit_cnt_r != ZERO_C);

    case ({push_fire_s, send_s})
      2'b10:   fifo_cnt_nxt_s = fifo_cnt_r + ONE_C;
      2'b01:   fifo_cnt_nxt_s = fifo_cnt_r - ONE_C;
      default: fifo_cnt_nxt_s = fifo_cnt_r;
    endcase

    // A return with the counter already full is a router protocol error
    case ({credit_i, send_s})
      2'b10: begin
        if (credit_cnt_r == CREDITS_C) begin
          credit_cnt_nxt_s = credit_cnt_r;
          err_set_s        = 1'b1;
        end else begin
          credit_cnt_nxt_s = credit_cnt_r + ONE_C;
          err_set_s        = 1'b0;
        end
      end
      2'b01:   credit_cnt_nxt_s = credit_cnt_r - ONE_C;
      default: credit_cnt_nxt_s = credit_cnt_r;
    endcase
  end

  // Flit storage: the tail entry is written on an accepted push
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (push_fire_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers, occupancy, credit count and the sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r     <= {PTR_W{1'b0}};
      rd_ptr_r     <= {PTR_W{1'b0}};
      fifo_cnt_r   <= ZERO_C;
      credit_cnt_r <= CREDITS_C;
      err_r        <= 1'b0;
    end else begin
      if (push_fire_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      end
      if (send_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end
      fifo_cnt_r   <= fifo_cnt_nxt_s;
      credit_cnt_r <= credit_cnt_nxt_s;
      err_r        <= err_r | err_set_s;
    end
  end

  // Router-facing register: valid for one cycle per send, data holds otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= 1'b0;
      data_r  <= {DATA_W{1'b0}};
    end else begin
      valid_r <= send_s;
      if (send_s) begin
        data_r <= mem_r[rd_ptr_r];
      end
    end
  end

  assign push_ready   = push_ready_s;
  assign valid_o      = valid_r;
  assign data_o       = data_r;
  assign credit_cnt_o = credit_cnt_r;
  assign fifo_cnt_o   = fifo_cnt_r;
  assign credit_err_o = err_r;

endmodule

// File: tb/tb_noc_flit_injector.sv
// Scoreboard bench for noc_flit_injector. Stimulus queues the expected flit
// stream; a negedge monitor pops and compares each flit the DUT presents.

module tb_noc_flit_injector;

  logic        clk;
  logic        rst;
  logic        push_valid;
  logic [15:0] push_data;
  logic        push_ready;
  logic        valid_o;
  logic [15:0] data_o;
  logic        credit_i;
  logic [2:0]  credit_cnt_o;
  logic [2:0]  fifo_cnt_o;
  logic        credit_err_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_sent   = 0;
  int          base;
  logic [15:0] exp_q [$];

  noc_flit_injector #(
    .DATA_W(16), .FIFO_DEPTH(4), .CREDITS(4)
  ) dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
    .valid_o(valid_o), .data_o(data_o),
    .credit_i(credit_i),
    .credit_cnt_o(credit_cnt_o), .fifo_cnt_o(fifo_cnt_o),
    .credit_err_o(credit_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    push_valid = 1'b1;
    push_data  = d;
    exp_q.push_back(d);
    cycle();
    push_valid = 1'b0;
  endtask

  // Monitor: every presented flit must be the next one expected
  always @(negedge clk) begin
    if (!rst && valid_o) begin
      n_sent++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_flit: got %0h, expected no flit", data_o);
      end else begin
        check("flit_order", {16'h0, data_o}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    rst        = 1'b0;
    push_valid = 1'b0;
    push_data  = 16'h0;
    credit_i   = 1'b0;

    // Reset values
    #1 rst = 1'b1;
    #1;
    check("rst_credit_cnt", 32'(credit_cnt_o), 32'd4);
    check("rst_fifo_cnt",   32'(fifo_cnt_o),   32'd0);
    check("rst_valid",      32'(valid_o),      32'd0);
    check("rst_data",       32'(data_o),       32'd0);
    check("rst_push_ready", 32'(push_ready),   32'd0);
    check("rst_err",        32'(credit_err_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cycle();
    check("ready_after_rst", 32'(push_ready), 32'd1);

    // Basic latency: push at edge 1, visible after edge 2
    push(16'hA5A5);
    check("lat_no_early_valid", 32'(valid_o), 32'd0);
    cycle();
    check("lat_valid",  32'(valid_o),      32'd1);
    check("lat_data",   32'(data_o),       32'hA5A5);
    check("lat_credit", 32'(credit_cnt_o), 32'd3);
    credit_i = 1'b1;
    cycle();
    credit_i = 1'b0;
    check("credit_restored", 32'(credit_cnt_o), 32'd4);
    check("valid_one_cycle", 32'(valid_o),      32'd0);

    // Credit exhaustion: 6 flits, only 4 credits
    base = n_sent;
    for (int i = 1; i <= 6; i++) begin
      push(16'(i));
    end
    repeat (3) cycle();
    check("exh_sent",    32'(n_sent - base), 32'd4);
    check("exh_credit",  32'(credit_cnt_o),  32'd0);
    check("exh_fifo",    32'(fifo_cnt_o),    32'd2);
    check("exh_valid",   32'(valid_o),       32'd0);
    credit_i = 1'b1;
    cycle();
    credit_i = 1'b0;
    check("ret_not_yet", 32'(valid_o),      32'd0);
    check("ret_credit",  32'(credit_cnt_o), 32'd1);
    cycle();
    check("ret_valid",   32'(valid_o),      32'd1);
    check("ret_data",    32'(data_o),       32'h0005);
    check("ret_credit0", 32'(credit_cnt_o), 32'd0);
    check("ret_fifo",    32'(fifo_cnt_o),   32'd1);

    // FIFO full with no credits; extra pushes must be refused
    push(16'h0101);
    push(16'h0102);
    push(16'h0103);
    check("full_fifo",  32'(fifo_cnt_o), 32'd4);
    check("full_ready", 32'(push_ready), 32'd0);
    push_valid = 1'b1;
    push_data  = 16'hDEAD;
    repeat (2) cycle();
    push_valid = 1'b0;
    check("full_hold_fifo",  32'(fifo_cnt_o), 32'd4);
    check("full_hold_ready", 32'(push_ready), 32'd0);

    // Credit pulse every cycle with one credit: continuous stream
    credit_i = 1'b1;
    cycle();
    check("strm_first_credit", 32'(credit_cnt_o), 32'd1);
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("strm_valid",  32'(valid_o),      32'd1);
      check("strm_credit", 32'(credit_cnt_o), 32'd1);
    end
    credit_i = 1'b0;
    cycle();
    check("strm_last_valid",  32'(valid_o),      32'd1);
    check("strm_last_credit", 32'(credit_cnt_o), 32'd0);
    check("strm_last_fifo",   32'(fifo_cnt_o),   32'd0);
    credit_i = 1'b1;
    repeat (4) cycle();
    credit_i = 1'b0;
    check("refill_credit", 32'(credit_cnt_o), 32'd4);
    check("refill_no_err", 32'(credit_err_o), 32'd0);

    // Credit overflow: saturate and set sticky error
    credit_i = 1'b1;
    cycle();
    credit_i = 1'b0;
    check("ovf_credit", 32'(credit_cnt_o), 32'd4);
    check("ovf_err",    32'(credit_err_o), 32'd1);
    cycle();
    check("ovf_sticky", 32'(credit_err_o), 32'd1);

    // Asynchronous reset mid-cycle with a flit queued and another offered
    push(16'h7777);
    push_valid = 1'b1;
    push_data  = 16'h8888;
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    push_valid = 1'b0;
    check("mid_rst_fifo",   32'(fifo_cnt_o),   32'd0);
    check("mid_rst_credit", 32'(credit_cnt_o), 32'd4);
    check("mid_rst_valid",  32'(valid_o),      32'd0);
    check("mid_rst_ready",  32'(push_ready),   32'd0);
    check("mid_rst_err",    32'(credit_err_o), 32'd0);
    check("mid_rst_data",   32'(data_o),       32'd0);
    @(negedge clk);
    rst = 1'b0;
    cycle();
    check("post_rst_ready", 32'(push_ready), 32'd1);
    check("post_rst_valid", 32'(valid_o),    32'd0);

    // Traffic resumes normally after reset
    push(16'h1234);
    cycle();
    check("post_rst_flit_valid", 32'(valid_o), 32'd1);
    check("post_rst_flit_data",  32'(data_o),  32'h1234);

    // Bounded drain: every expected flit must have been seen
    for (int w = 0; w < 20 && exp_q.size() != 0; w++) begin
      cycle();
    end
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/noc_flit_injector.md
Name: noc_flit_injector

Overview:
- Upstream injection stage for a NoC router input port. Accepts 16-bit flits from a local source over a valid/ready handshake and buffers them in a small FIFO.
- Drives flits to the router's valid_i/data_i only when a downstream credit is available.
- Tracks downstream buffer space with a credit counter, replenished by the router's one-cycle credit pulse.

Parameters:
- DATA_W, 16: flit width.
- FIFO_DEPTH, 4: local flit buffer entries; power of 2, at least 2.
- CREDITS, 4: initial credit count, equal to the router input buffer depth; at least 1.
- CNT_W, $clog2(max(FIFO_DEPTH,CREDITS)+1): width of the count outputs (derived).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset.
- push_valid  in  1  local source offers a flit.
- push_data  in  DATA_W  local flit.
- push_ready  out  1  FIFO can accept a flit this cycle.
- valid_o  out  1  flit valid to router (connects to router valid_i).
- data_o  out  DATA_W  flit to router (connects to router data_i).
- credit_i  in  1  credit return pulse from router (router credit_o); one pulse returns one credit.
- credit_cnt_o  out  CNT_W  current credit count.
- fifo_cnt_o  out  CNT_W  current FIFO occupancy.
- credit_err_o  out  1  sticky flag: credit returned while the counter was already at CREDITS.

Behaviour:
- Reset: rst, asynchronous, active-high.
- Values while rst is asserted:
  - FIFO empty; pointers 0; fifo_cnt_o=0.
  - push_ready=0, valid_o=0, data_o=0, credit_err_o=0.
  - credit_cnt_o=CREDITS.
- Reset mid-operation flushes the FIFO and any in-flight output and restores credits. The router is reset by the same rst.
- push_ready = !rst && (fifo_cnt < FIFO_DEPTH), using the registered count.
  - A pop in the same cycle does not free a slot until the next cycle.
- Push fires when push_valid && push_ready at posedge; push_data is written at the tail.
- Send decision at each posedge uses pre-edge state: send = (fifo_cnt > 0) && (credit_cnt > 0).
- On send:
  - Pop the head into the data_o register and set valid_o=1 for exactly the following cycle.
  - Without a send, valid_o=0 and data_o holds its last value.
- Back-to-back sends on consecutive cycles are allowed when flits and credits permit.
- Latency: a flit pushed at edge k into an empty FIFO with credit_cnt>0 appears on valid_o/data_o in the cycle after edge k+1.
  - Push-to-output latency is 2 cycles.
  - Flit order is strictly FIFO.
- Simultaneous push and pop: both occur; fifo_cnt is unchanged. Pointers wrap modulo FIFO_DEPTH.
- Credit update: credit_cnt_next = credit_cnt - send + credit_i.
  - Send and credit_i in the same cycle leave the count unchanged.
  - A credit returned at edge k is usable for a send decision at edge k+1.
- credit_cnt==0: no send, the FIFO holds, and push continues until full.
- Credit overflow: credit_i=1 with credit_cnt==CREDITS and no send.
  - Count saturates at CREDITS.
  - credit_err_o is set and stays set until rst.
- credit_cnt never underflows; sends are gated by credit_cnt>0.
- No combinational path from credit_i or push_valid to any output. All outputs are registered or derived from registered state.

Test Plan:
- Reset values: assert rst asynchronously mid-cycle -> immediately credit_cnt_o=4, fifo_cnt_o=0, valid_o=0, push_ready=0, credit_err_o=0; after release push_ready=1.
- Basic latency: push 0xA5A5 at edge 1 -> valid_o=1 with data_o=0xA5A5 in the cycle after edge 2; credit_cnt_o=3.
- Credit exhaustion: push 0x0001..0x0006 back-to-back with credit_i=0.
  - Expect exactly 4 valid_o pulses carrying 0x0001..0x0004; credit_cnt_o=0; fifo_cnt_o=2.
  - One credit_i pulse -> 0x0005 sent on the next edge.
- FIFO full: credit_cnt forced to 0 (as above), push 4 flits -> fifo_cnt_o=4 and push_ready=0; push_valid held high does not overwrite the head.
- Simultaneous send and credit return with credit_cnt=1 and 3 flits queued: credit_i pulse on every cycle -> continuous valid_o stream and credit_cnt_o stays 1.
- Credit overflow: from reset, pulse credit_i with no traffic -> credit_cnt_o stays 4 and credit_err_o=1; rst clears credit_err_o.
